// File: rtl/mem_pkg.sv
// Shared memory-bus definitions: word/address widths, the I/O address and the
// ownership states of main memory (idle, program load, processor run).
package mem_pkg;
   localparam int MEM_DATA_W = 16;
   localparam int MEM_ADDR_W = 12;
   localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;
   localparam logic [MEM_ADDR_W-1:0] MEM_IO_ADDR = 12'hFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;
endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with a registered read port.
// Reads return the word as it was before a same-cycle write.
module ram_sp
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W
) (
   input  logic              i_clock,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [1 << ADDR_W];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clock) begin
      if (i_we)
         r_mem[i_addr] <= i_wdata;
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/main_memory.sv
// Processor-side memory responder: program loader, 4K x 16 store and one
// memory-mapped I/O word. run_en tells the processor it owns the memory.
module main_memory
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter logic [ADDR_W-1:0] IO_ADDR = MEM_IO_ADDR
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic              m_rw,
   input  logic [DATA_W-1:0] m_data,
   output logic [DATA_W-1:0] m_q,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              run_en,
   input  logic [DATA_W-1:0] io_in,
   output logic [DATA_W-1:0] io_out
);
   localparam int DEPTH = 1 << ADDR_W;

   state_t            r_state;
   logic [ADDR_W:0]   r_ld_ptr;
   logic              r_ld_ready;
   logic              r_run_en;
   logic [DATA_W-1:0] r_io_out;
   logic [DATA_W-1:0] r_io_val;
   logic [DATA_W-1:0] r_q_hold;
   logic              r_rd_valid;
   logic              r_io_sel;

   logic              w_io_hit;
   logic              w_ld_xfer;
   logic              w_ld_end;
   logic              w_cpu_wr;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [DATA_W-1:0] w_ram_wdata;
   logic [DATA_W-1:0] w_ram_rdata;
   logic [DATA_W-1:0] w_q;

   assign w_io_hit  = (m_addr == IO_ADDR);
   assign w_ld_xfer = (r_state == LOAD) && ld_valid;
   assign w_ld_end  = w_ld_xfer && (ld_last || (r_ld_ptr == (ADDR_W+1)'(DEPTH-1)));
   // A reload request in RUN takes priority over a processor write on the same edge.
   assign w_cpu_wr  = (r_state == RUN) && m_rw && !ld_start;

   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_addr  = m_addr;
      w_ram_wdata = m_data;
      if (r_state == LOAD) begin
         w_ram_we    = ld_valid;
         w_ram_addr  = r_ld_ptr[ADDR_W-1:0];
         w_ram_wdata = ld_data;
      end else begin
         w_ram_we = w_cpu_wr && !w_io_hit;
      end
   end

   ram_sp #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .i_clock (clock),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_ld_ptr   <= '0;
         r_ld_ready <= 1'b0;
         r_run_en   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ld_start) begin
                  r_state    <= LOAD;
                  r_ld_ptr   <= '0;
                  r_ld_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (w_ld_xfer)
                  r_ld_ptr <= r_ld_ptr + (ADDR_W+1)'(1);
               if (w_ld_end) begin
                  r_state    <= RUN;
                  r_ld_ready <= 1'b0;
                  r_run_en   <= 1'b1;
               end
            end
            RUN: begin
               if (ld_start) begin
                  r_state    <= LOAD;
                  r_ld_ptr   <= '0;
                  r_ld_ready <= 1'b1;
                  r_run_en   <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_ld_ready <= 1'b0;
               r_run_en   <= 1'b0;
            end
         endcase
      end
   end

   // m_q follows the RAM/I-O read path after a RUN cycle and otherwise holds.
   assign w_q = r_rd_valid ? (r_io_sel ? r_io_val : w_ram_rdata) : r_q_hold;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_io_out   <= '0;
         r_io_val   <= '0;
         r_q_hold   <= '0;
         r_rd_valid <= 1'b0;
         r_io_sel   <= 1'b0;
      end else begin
         r_q_hold   <= w_q;
         r_rd_valid <= (r_state == RUN);
         r_io_sel   <= w_io_hit;
         r_io_val   <= io_in;
         if (w_cpu_wr && w_io_hit)
            r_io_out <= m_data;
      end
   end

   assign m_q      = w_q;
   assign ld_ready = r_ld_ready;
   assign run_en   = r_run_en;
   assign io_out   = r_io_out;
endmodule

// File: tb/tb_main_memory.sv
// Randomized bench for main_memory against a word-array/ownership model.
`timescale 1ns/1ps
module tb_main_memory;
   localparam int DW    = 16;
   localparam int AW    = 12;
   localparam int DEPTH = 4096;
   localparam logic [AW-1:0] IOA = 12'hFFF;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] m_addr = '0;
   logic          m_rw = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic [DW-1:0] m_q;
   logic          ld_start = 1'b0;
   logic          ld_valid = 1'b0;
   logic [DW-1:0] ld_data = '0;
   logic          ld_last = 1'b0;
   logic          ld_ready;
   logic          run_en;
   logic [DW-1:0] io_in = '0;
   logic [DW-1:0] io_out;

   main_memory dut (
      .clock    (clock),
      .reset    (reset),
      .m_addr   (m_addr),
      .m_rw     (m_rw),
      .m_data   (m_data),
      .m_q      (m_q),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_last  (ld_last),
      .ld_ready (ld_ready),
      .run_en   (run_en),
      .io_in    (io_in),
      .io_out   (io_out)
   );

   always #5 clock = ~clock;

   typedef enum int {M_IDLE, M_LOAD, M_RUN} mstate_t;
   mstate_t       ms = M_IDLE;
   int            mptr = 0;
   logic [DW-1:0] mmem [DEPTH];
   bit            mknown [DEPTH];
   logic [DW-1:0] mq = '0;
   bit            mq_known = 1'b1;
   logic [DW-1:0] mio = '0;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   task automatic model_reset();
      ms = M_IDLE;
      mptr = 0;
      mq = '0;
      mq_known = 1'b1;
      mio = '0;
   endtask

   // What one rising edge does to the memory system, given the current inputs.
   task automatic model_edge();
      if (reset) return;
      case (ms)
         M_IDLE: if (ld_start) begin ms = M_LOAD; mptr = 0; end
         M_LOAD: begin
            if (ld_valid) begin
               mmem[mptr] = ld_data;
               mknown[mptr] = 1'b1;
               mptr++;
               if (ld_last || mptr == DEPTH) ms = M_RUN;
            end
         end
         M_RUN: begin
            if (m_addr == IOA) begin
               mq = io_in;
               mq_known = 1'b1;
            end else begin
               mq = mmem[m_addr];
               mq_known = mknown[m_addr];
            end
            if (ld_start) begin
               ms = M_LOAD;
               mptr = 0;
               mq_known = 1'b0;
            end else if (m_rw) begin
               if (m_addr == IOA) mio = m_data;
               else begin
                  mmem[m_addr] = m_data;
                  mknown[m_addr] = 1'b1;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #2;
   endtask

   task automatic load_word(input logic [DW-1:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic cpu(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d);
      m_addr = a;
      m_rw   = rw;
      m_data = d;
      tick();
      m_rw = 1'b0;
   endtask

   task automatic random_run(input int n);
      for (int k = 0; k < n; k++) begin
         case ($urandom_range(0, 3))
            0:       m_addr = IOA;
            1:       m_addr = AW'($urandom_range(0, 31));
            default: m_addr = AW'($urandom);
         endcase
         m_rw     = ($urandom_range(0, 3) == 0);
         m_data   = DW'($urandom);
         io_in    = DW'($urandom);
         ld_valid = ($urandom_range(0, 7) == 0);
         ld_last  = ($urandom_range(0, 1) == 1);
         ld_data  = DW'($urandom);
         tick();
      end
      m_rw = 1'b0;
      ld_valid = 1'b0;
      ld_last = 1'b0;
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("ld_ready", {31'd0, ld_ready}, {31'd0, ms == M_LOAD});
         chk("run_en", {31'd0, run_en}, {31'd0, ms == M_RUN});
         chk("io_out", {16'd0, io_out}, {16'd0, mio});
         chk("ld_ptr", {19'd0, dut.r_ld_ptr}, mptr);
         if (mq_known)
            chk("m_q", {16'd0, m_q}, {16'd0, mq});
      end
   end

   initial begin
      model_reset();
      chk_en = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_m_q", {16'd0, m_q}, 32'h0);
      chk("rst_ld_ready", {31'd0, ld_ready}, 32'h0);
      chk("rst_run_en", {31'd0, run_en}, 32'h0);
      chk("rst_io_out", {16'd0, io_out}, 32'h0);

      // First program load: three words, last one flagged
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("load_ready_up", {31'd0, ld_ready}, 32'h1);
      load_word(16'h8001, 1'b0);
      load_word(16'h8802, 1'b0);
      load_word(16'hC0A0, 1'b1);
      chk("load_end_ready", {31'd0, ld_ready}, 32'h0);
      chk("load_end_run_en", {31'd0, run_en}, 32'h1);

      cpu(12'h001, 1'b0, '0);
      chk("read_a1", {16'd0, m_q}, 32'h8802);
      cpu(12'h000, 1'b0, '0);
      chk("read_a0", {16'd0, m_q}, 32'h8001);
      cpu(12'h002, 1'b0, '0);
      chk("read_a2", {16'd0, m_q}, 32'hC0A0);

      cpu(12'h010, 1'b1, 16'h1111);
      cpu(12'h010, 1'b1, 16'hBEEF);
      chk("rbw_old", {16'd0, m_q}, 32'h1111);
      cpu(12'h010, 1'b0, '0);
      chk("read_beef", {16'd0, m_q}, 32'hBEEF);

      cpu(IOA, 1'b1, 16'h00FF);
      chk("io_write", {16'd0, io_out}, 32'h00FF);
      io_in = 16'h1234;
      cpu(IOA, 1'b0, '0);
      chk("io_read", {16'd0, m_q}, 32'h1234);

      // Reload requested together with a processor write: write must be dropped
      cpu(12'h020, 1'b1, 16'h5555);
      m_addr = 12'h020;
      m_rw = 1'b1;
      m_data = 16'hAAAA;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      m_rw = 1'b0;
      chk("reload_ready", {31'd0, ld_ready}, 32'h1);
      chk("reload_run_en", {31'd0, run_en}, 32'h0);
      load_word(16'h7777, 1'b0);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      load_word(16'h6666, 1'b1);
      cpu(12'h020, 1'b0, '0);
      chk("drop_write", {16'd0, m_q}, 32'h5555);
      cpu(12'h000, 1'b0, '0);
      chk("reload_a0", {16'd0, m_q}, 32'h7777);

      random_run(400);

      // Full-depth load with no ld_last and processor noise on the bus
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      for (int i = 0; i < DEPTH; ) begin
         ld_valid = ($urandom_range(0, 3) != 0);
         ld_data  = DW'($urandom);
         m_addr   = AW'($urandom);
         m_rw     = ($urandom_range(0, 1) == 1);
         m_data   = DW'($urandom);
         tick();
         if (ld_valid) i++;
      end
      ld_valid = 1'b0;
      m_rw = 1'b0;
      chk("forced_run_en", {31'd0, run_en}, 32'h1);
      chk("forced_ready", {31'd0, ld_ready}, 32'h0);
      chk("forced_ptr", {19'd0, dut.r_ld_ptr}, 32'h1000);

      random_run(600);

      // Reset in the middle of a load
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      load_word(16'hA1A1, 1'b0);
      load_word(16'hB2B2, 1'b0);
      reset = 1'b1;
      model_reset();
      #1;
      chk("midrst_ready", {31'd0, ld_ready}, 32'h0);
      chk("midrst_run_en", {31'd0, run_en}, 32'h0);
      chk("midrst_m_q", {16'd0, m_q}, 32'h0);
      tick();
      reset = 1'b0;
      cpu(12'h005, 1'b1, 16'hDEAD);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      load_word(16'h0C0C, 1'b1);
      cpu(12'h001, 1'b0, '0);
      chk("kept_after_rst", {16'd0, m_q}, 32'hB2B2);
      cpu(12'h005, 1'b0, '0);
      chk("idle_write_drop", {16'd0, m_q}, {16'd0, mmem[5]});
      cpu(12'h000, 1'b0, '0);
      chk("post_rst_a0", {16'd0, m_q}, 32'h0C0C);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
